// File: rtl/note_mixer.sv
// Audio mixer: once per sample period it scans every voice in turn, sums the
// enabled and valid samples, scales and clips the sum, and offers it downstream.
module note_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 12,
  parameter int OUT_W      = 12,
  parameter int SHIFT      = 1,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
  input  logic [NUM_VOICES-1:0]          voice_valid,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  output logic [NUM_VOICES-1:0]          agg_ack,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sample_tick,
  output logic                           overrun,
  output logic                           saturated,
  input  logic                           clear_flags,
  output logic [1:0]                     dbg_state
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int MIX_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int DW    = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE, SCAN, SCALE, OUTPUT} state_t;

  // Handshake: a sample moves downstream on every rising clk edge where
  // out_valid && out_ready; out_valid and out_data stay frozen until then.

  state_t             r_state;
  logic [DW-1:0]      r_div;
  logic [VW-1:0]      r_v;
  logic [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_overrun;
  logic               r_saturated;

  logic               w_tick;
  logic               w_take;
  logic               w_clip;
  logic               w_set_ovr;
  logic               w_set_sat;
  logic [MIX_W-1:0]   w_mix;
  logic [SAMPLE_W-1:0] w_voice [NUM_VOICES];

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_voice[i] = voice_data[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign w_tick    = (r_div == DW'(SAMPLE_DIV - 1));
  assign w_take    = (r_state == SCAN) && voice_enable[r_v] && voice_valid[r_v];
  assign w_mix     = MIX_W'(r_acc) >> SHIFT;
  assign w_clip    = (w_mix > MIX_W'({OUT_W{1'b1}}));
  assign w_set_ovr = w_tick && (r_state != IDLE);
  assign w_set_sat = (r_state == SCALE) && w_clip;

  // The ack must coincide with the cycle the voice sample is summed.
  always_comb begin
    agg_ack = '0;
    if (w_take) agg_ack[r_v] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_v         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_acc   <= '0;
            r_v     <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_take) r_acc <= r_acc + ACC_W'(w_voice[r_v]);
          if (r_v == VW'(NUM_VOICES - 1)) begin
            r_state <= SCALE;
          end else begin
            r_v <= r_v + 1'b1;
          end
        end
        SCALE: begin
          r_out_data  <= w_clip ? {OUT_W{1'b1}} : w_mix[OUT_W-1:0];
          r_out_valid <= 1'b1;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_flags takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      r_overrun   <= w_set_ovr | (r_overrun & ~clear_flags);
      r_saturated <= w_set_sat | (r_saturated & ~clear_flags);
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign sample_tick = w_tick;
  assign overrun     = r_overrun;
  assign saturated   = r_saturated;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_note_mixer.sv
// Randomized bench for note_mixer: per-period sums computed from plain
// arithmetic, compared against the DUT via a single checking task.
module tb_note_mixer;
  localparam int NV  = 4;
  localparam int SW  = 12;
  localparam int OW  = 12;
  localparam int SH  = 1;
  localparam int DIV = 16;
  localparam int MAXO = (1 << OW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NV*SW-1:0] voice_data = '0;
  logic [NV-1:0]    voice_valid = '0;
  logic [NV-1:0]    voice_enable = '0;
  logic [NV-1:0]    agg_ack;
  logic [OW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             sample_tick;
  logic             overrun;
  logic             saturated;
  logic             clear_flags = 1'b0;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_sat  = 1'b0;
  bit exp_ovr  = 1'b0;
  logic [OW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  note_mixer #(
    .NUM_VOICES(NV), .SAMPLE_W(SW), .OUT_W(OW), .SHIFT(SH), .SAMPLE_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .voice_data(voice_data), .voice_valid(voice_valid),
    .voice_enable(voice_enable), .agg_ack(agg_ack), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sample_tick(sample_tick),
    .overrun(overrun), .saturated(saturated), .clear_flags(clear_flags),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_tick();
    int c;
    c = 0;
    while (c < 3 * DIV) begin
      @(negedge clk); #1;
      if (sample_tick) return;
      c++;
    end
    check("tick_timeout", 32'd0, 32'd1);
  endtask

  // One full sample period: voice i gets d[i] only in its own scan cycle,
  // other voices see random garbage then.
  task automatic do_period(input logic [NV-1:0][SW-1:0] d, input logic [NV-1:0] val,
                           input logic [NV-1:0] en, input bit clr, input bit stall);
    int sum, mix, k;
    bit clip;
    logic [OW-1:0] held;
    sum = 0;
    wait_tick();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      voice_data   = {$urandom, $urandom};
      voice_valid  = NV'($urandom);
      voice_data[i*SW +: SW] = d[i];
      voice_valid[i] = val[i];
      voice_enable = en;
      #1;
      check("ack", agg_ack, (en[i] && val[i]) ? (32'd1 << i) : 32'd0);
      if (en[i] && val[i]) sum += int'(d[i]);
    end
    mix  = sum >> SH;
    clip = (mix > MAXO);
    exp_q.push_back(clip ? OW'(MAXO) : OW'(mix));
    @(negedge clk);
    clear_flags = clr;
    #1;
    check("valid_early", out_valid, 0);
    check("ack_idle", agg_ack, 0);
    if (clip) exp_sat = 1'b1;
    else if (clr) exp_sat = 1'b0;
    if (clr) exp_ovr = 1'b0;
    @(negedge clk);
    clear_flags = 1'b0;
    #1;
    check("valid_lat", out_valid, 1);
    held = exp_q.pop_front();
    check("out_data", out_data, held);
    check("saturated", saturated, exp_sat);
    check("overrun", overrun, exp_ovr);
    if (stall) begin
      wait_tick();
      exp_ovr = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        voice_valid = '1; voice_enable = '1;
        #1;
        check("stall_noscan", agg_ack, 0);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
        check("stall_ovr", overrun, exp_ovr);
      end
    end else begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(negedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("xfer_drop", out_valid, 0);
  endtask

  initial begin
    logic [NV-1:0][SW-1:0] d;
    int c;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ack", agg_ack, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_flags", {overrun, saturated}, 0);
    @(negedge clk); rst_n = 1'b1;

    d = {12'd400, 12'd300, 12'd200, 12'd100};
    do_period(d, 4'b1111, 4'b1111, 1'b0, 1'b0);
    d = {NV{12'd4095}};
    do_period(d, 4'b1111, 4'b1111, 1'b0, 1'b0);
    d = {NV{12'd1000}};
    do_period(d, 4'b1111, 4'b0101, 1'b1, 1'b0);
    d = {NV{12'd10}};
    do_period(d, 4'b1101, 4'b1111, 1'b0, 1'b0);
    do_period(d, 4'b1111, 4'b0000, 1'b0, 1'b0);
    d = {12'd7, 12'd4095, 12'd4095, 12'd4095};
    do_period(d, 4'b1111, 4'b1111, 1'b1, 1'b0);
    d = {12'd1, 12'd2, 12'd3, 12'd4};
    do_period(d, 4'b1111, 4'b1111, 1'b0, 1'b1);
    do_period(d, 4'b1111, 4'b1111, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NV; i++)
        d[i] = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(3000, 4095))
                                           : SW'($urandom_range(0, 4095));
      do_period(d, NV'($urandom), NV'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset in the middle of a scan, at voice 2.
    wait_tick();
    voice_valid = '1; voice_enable = '1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", agg_ack, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_flags", {overrun, saturated}, 0);
    exp_sat = 1'b0; exp_ovr = 1'b0; exp_q.delete();
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_hold_ack", agg_ack, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    c = 0;
    while (!sample_tick && c < 3 * DIV) begin
      check("post_rst_ack", agg_ack, 0);
      @(negedge clk); #1;
      c++;
    end
    check("first_tick", c, DIV - 1);
    voice_enable = '0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    d = {12'd40, 12'd30, 12'd20, 12'd10};
    do_period(d, 4'b1111, 4'b1111, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
